xy_point_scheduler: RTL and testbench

XY_POINT_SCHEDULER -- requirements
Module: xy_point_scheduler

---
 rtl/xy_sched_pkg.sv | 20 ++
 rtl/sched_timer.sv | 28 ++
 rtl/xy_point_scheduler.sv | 132 +++++++++++++
 tb/tb_xy_point_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_sched_pkg.sv
// Shared definitions for the XY point scheduler: FSM states, DAC axis codes
// and the DAC word width.
package xy_sched_pkg;

    localparam int DAC_W = 12;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_X = 3'd1,
        ST_WAIT_X = 3'd2,
        ST_SEND_Y = 3'd3,
        ST_WAIT_Y = 3'd4,
        ST_LATCH  = 3'd5,
        ST_DWELL  = 3'd6
    } sched_state_t;

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the
// count sits at zero. Shared by the LDAC pulse and the dwell hold.
module sched_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] count_value,
    input  logic             count_en,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= count_value;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/xy_point_scheduler.sv
// Takes XY points over a valid/ready handshake, sends X then Y to the SPI DAC
// driver, pulses the active-low LDAC latch and holds each point for its dwell.
module xy_point_scheduler
    import xy_sched_pkg::*;
#(
    parameter int LDAC_CYCLES = 2,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DAC_W-1:0]       pt_x,
    input  logic [DAC_W-1:0]       pt_y,
    input  logic [DWELL_WIDTH-1:0] pt_dwell,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    output logic [DAC_W-1:0]       dac_value,
    output logic                   dac_axis,
    output logic                   dac_strobe,
    input  logic                   dac_ready,
    output logic                   ldac_pin,
    output logic                   busy,
    output logic [15:0]            points_done
);

    // The timer must hold both the LDAC pulse length (up to 15) and any dwell.
    localparam int TMR_W = (DWELL_WIDTH > 4) ? DWELL_WIDTH : 4;
    localparam logic [TMR_W-1:0] LDAC_LOAD = TMR_W'(LDAC_CYCLES - 1);

    sched_state_t state;
    sched_state_t state_nxt;

    logic [DAC_W-1:0]       x_q;
    logic [DAC_W-1:0]       y_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [15:0]            done_cnt;

    logic             accept;
    logic             send_fire;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_en;
    logic             tmr_expired;

    assign accept    = pt_valid && pt_ready;
    assign send_fire = ((state == ST_SEND_X) || (state == ST_SEND_Y)) && dac_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // dac_strobe is high only in the first WAIT cycle, which is exactly the
    // cycle whose dac_ready must be ignored (the driver drops it a cycle late).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)                   state_nxt = ST_SEND_X;
            ST_SEND_X: if (dac_ready)                state_nxt = ST_WAIT_X;
            ST_WAIT_X: if (!dac_strobe && dac_ready) state_nxt = ST_SEND_Y;
            ST_SEND_Y: if (dac_ready)                state_nxt = ST_WAIT_Y;
            ST_WAIT_Y: if (!dac_strobe && dac_ready) state_nxt = ST_LATCH;
            ST_LATCH:  if (tmr_expired)              state_nxt = ST_DWELL;
            ST_DWELL:  if (tmr_expired)              state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pt_ready = (state == ST_IDLE) && !reset;
        busy     = (state != ST_IDLE);
        ldac_pin = (state != ST_LATCH);
    end

    // One timer serves both holds: loaded with LDAC_CYCLES-1 on entry to
    // LATCH, then reloaded with the dwell on the LATCH-to-DWELL step.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = LDAC_LOAD;
        tmr_en    = (state == ST_LATCH) || (state == ST_DWELL);
        if ((state == ST_WAIT_Y) && (state_nxt == ST_LATCH)) begin
            tmr_load = 1'b1;
        end else if ((state == ST_LATCH) && tmr_expired) begin
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(dwell_q);
        end
    end

    sched_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .count_value(tmr_value),
        .count_en   (tmr_en),
        .expired    (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            x_q     <= pt_x;
            y_q     <= pt_y;
            dwell_q <= pt_dwell;
        end
    end

    // Value and axis only change together with a strobe, so they stay stable
    // for the driver until the next command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_strobe <= 1'b0;
            dac_value  <= '0;
            dac_axis   <= AXIS_X;
            done_cnt   <= '0;
        end else begin
            dac_strobe <= send_fire;
            if (send_fire) begin
                dac_value <= (state == ST_SEND_X) ? x_q : y_q;
                dac_axis  <= (state == ST_SEND_X) ? AXIS_X : AXIS_Y;
            end
            if ((state == ST_DWELL) && tmr_expired) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign points_done = done_cnt;

endmodule

// File: tb/tb_xy_point_scheduler.sv
// Self-checking bench for xy_point_scheduler: directed scenarios plus random
// points, checked against a queue-based model of the expected DAC commands.
module tb_xy_point_scheduler;
    import xy_sched_pkg::*;

    localparam int LDAC_CYCLES = 2;
    localparam int DWELL_WIDTH = 8;

    logic                   clk;
    logic                   reset;
    logic [11:0]            pt_x;
    logic [11:0]            pt_y;
    logic [DWELL_WIDTH-1:0] pt_dwell;
    logic                   pt_valid;
    logic                   pt_ready;
    logic [11:0]            dac_value;
    logic                   dac_axis;
    logic                   dac_strobe;
    logic                   dac_ready;
    logic                   ldac_pin;
    logic                   busy;
    logic [15:0]            points_done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // DAC driver model state
    logic hold_low    = 1'b0;
    logic drv_rdy     = 1'b1;
    bit   drv_pending = 1'b0;
    int   drv_busy    = 0;
    int   drv_cnt     = 0;
    assign dac_ready = drv_rdy && !hold_low;

    // observed and expected streams
    logic        got_axis[$];
    logic [11:0] got_val[$];
    logic        exp_axis[$];
    logic [11:0] exp_val[$];
    int          ldac_runs[$];
    int          dwell_runs[$];
    int          exp_dwell[$];
    int          strobe_cnt = 0;
    int          acc_cnt    = 0;
    logic [15:0] exp_done   = 16'd0;

    xy_point_scheduler #(
        .LDAC_CYCLES(LDAC_CYCLES),
        .DWELL_WIDTH(DWELL_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_dwell   (pt_dwell),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .dac_value  (dac_value),
        .dac_axis   (dac_axis),
        .dac_strobe (dac_strobe),
        .dac_ready  (dac_ready),
        .ldac_pin   (ldac_pin),
        .busy       (busy),
        .points_done(points_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver: logs each strobe, keeps ready high through the strobe cycle,
    // then drops it for drv_busy cycles.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            drv_pending = 1'b0;
            drv_cnt     = 0;
            drv_rdy     = 1'b1;
        end else begin
            if (dac_strobe) begin
                check("drv_idle_at_strobe", {30'd0, drv_pending, (drv_cnt != 0)}, 32'd0);
                got_axis.push_back(dac_axis);
                got_val.push_back(dac_value);
                strobe_cnt++;
                drv_pending = 1'b1;
            end else if (drv_pending) begin
                drv_pending = 1'b0;
                drv_cnt     = drv_busy;
            end else if (drv_cnt > 0) begin
                drv_cnt--;
            end
            drv_rdy = (drv_cnt == 0);
        end
    end

    // Monitor: accepts, LDAC low-pulse lengths, DWELL cycles after LDAC rises.
    logic ldac_prev = 1'b1;
    int   low_run   = 0;
    bit   meas      = 1'b0;
    int   dcnt      = 0;
    always @(negedge clk) begin
        if (reset) begin
            low_run   = 0;
            meas      = 1'b0;
            ldac_prev = 1'b1;
        end else begin
            if (pt_valid && pt_ready) acc_cnt++;
            if (!ldac_pin) begin
                low_run++;
            end else if (!ldac_prev) begin
                ldac_runs.push_back(low_run);
                low_run = 0;
                meas    = 1'b1;
                dcnt    = 0;
            end
            if (meas) begin
                if (busy) dcnt++;
                else begin
                    dwell_runs.push_back(dcnt);
                    meas = 1'b0;
                end
            end
            ldac_prev = ldac_pin;
        end
    end

    task automatic offer(input logic [11:0] x, input logic [11:0] y, input int dw, input bit completes);
        int n;
        n        = 0;
        pt_x     = x;
        pt_y     = y;
        pt_dwell = DWELL_WIDTH'(dw);
        pt_valid = 1'b1;
        @(negedge clk);
        while (!pt_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("accept_within_bound", 32'(n < 5000), 32'd1);
        @(posedge clk);
        #1;
        check("ready_low_after_accept", 32'(pt_ready), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);
        exp_axis.push_back(AXIS_X);
        exp_val.push_back(x);
        exp_axis.push_back(AXIS_Y);
        exp_val.push_back(y);
        if (completes) begin
            exp_dwell.push_back(dw + 1);
            exp_done++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_bound", 32'(n < 5000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_strobe_count"}, 32'(got_val.size()), 32'(exp_val.size()));
        while (got_val.size() > 0 && exp_val.size() > 0) begin
            check({tag, "_axis"}, 32'(got_axis.pop_front()), 32'(exp_axis.pop_front()));
            check({tag, "_value"}, 32'(got_val.pop_front()), 32'(exp_val.pop_front()));
        end
        got_axis.delete();
        got_val.delete();
        exp_axis.delete();
        exp_val.delete();
        check({tag, "_ldac_pulses"}, 32'(ldac_runs.size()), 32'(exp_dwell.size()));
        check({tag, "_dwell_holds"}, 32'(dwell_runs.size()), 32'(exp_dwell.size()));
        while (exp_dwell.size() > 0) begin
            if (ldac_runs.size() > 0)
                check({tag, "_ldac_low_cycles"}, 32'(ldac_runs.pop_front()), 32'(LDAC_CYCLES));
            if (dwell_runs.size() > 0)
                check({tag, "_dwell_cycles"}, 32'(dwell_runs.pop_front()), 32'(exp_dwell[0]));
            void'(exp_dwell.pop_front());
        end
        ldac_runs.delete();
        dwell_runs.delete();
        check({tag, "_points_done"}, 32'(points_done), 32'(exp_done));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int acc0;
        int str0;
        reset    = 1'b1;
        pt_x     = '0;
        pt_y     = '0;
        pt_dwell = '0;
        pt_valid = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ldac", 32'(ldac_pin), 32'd1);
        check("rst_strobe", 32'(dac_strobe), 32'd0);
        check("rst_value", 32'(dac_value), 32'd0);
        check("rst_axis", 32'(dac_axis), 32'd0);
        check("rst_points_done", 32'(points_done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_pt_ready", 32'(pt_ready), 32'd1);

        // basic point with a slow driver
        drv_busy = 33;
        offer(12'h123, 12'hABC, 0, 1'b1);
        pt_valid = 1'b0;
        wait_idle();
        compare_model("basic");

        // back-to-back points with pt_valid held high
        drv_busy = 3;
        acc0 = acc_cnt;
        str0 = strobe_cnt;
        offer(12'h001, 12'h002, 1, 1'b1);
        offer(12'h7FF, 12'h800, 0, 1'b1);
        offer(12'hFFF, 12'h000, 2, 1'b1);
        pt_valid = 1'b0;
        wait_idle();
        check("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
        check("b2b_strobes", 32'(strobe_cnt - str0), 32'd6);
        compare_model("b2b");

        // driver never ready: SEND_X must hold with no strobe
        drv_busy = 0;
        hold_low = 1'b1;
        offer(12'h0F0, 12'h00F, 1, 1'b1);
        pt_valid = 1'b0;
        str0 = strobe_cnt;
        repeat (100) @(negedge clk);
        check("hold_no_strobe", 32'(strobe_cnt - str0), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_strobe_low", 32'(dac_strobe), 32'd0);
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        @(negedge clk);
        check("release_strobe_not_yet", 32'(dac_strobe), 32'd0);
        @(negedge clk);
        check("release_strobe_next", 32'(dac_strobe), 32'd1);
        wait_idle();
        compare_model("hold");

        // dwell of 5 gives 6 DWELL cycles
        drv_busy = 1;
        offer(12'h001, 12'hFFE, 5, 1'b1);
        pt_valid = 1'b0;
        wait_idle();
        compare_model("dwell5");

        // counter wrap: stand in for 65535 completed points, then one more
        force dut.done_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.done_cnt;
        exp_done = 16'hFFFF;
        check("preload_points_done", 32'(points_done), 32'(exp_done));
        offer(12'h456, 12'h789, 0, 1'b1);
        pt_valid = 1'b0;
        wait_idle();
        compare_model("wrap");

        // random points, random driver latency, random gaps
        for (int i = 0; i < 8; i++) begin
            drv_busy = int'($urandom_range(0, 6));
            offer(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 9)), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                pt_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        pt_valid = 1'b0;
        wait_idle();
        compare_model("random");

        // asynchronous reset while waiting on the Y transfer
        drv_busy = 20;
        offer(12'h5A5, 12'h3C3, 4, 1'b0);
        pt_valid = 1'b0;
        n = 0;
        while (got_val.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_y", 32'(n < 500), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_ldac", 32'(ldac_pin), 32'd1);
        check("async_strobe", 32'(dac_strobe), 32'd0);
        check("async_value", 32'(dac_value), 32'd0);
        check("async_axis", 32'(dac_axis), 32'd0);
        check("async_points_done", 32'(points_done), 32'd0);
        check("async_pt_ready", 32'(pt_ready), 32'd0);
        exp_done = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("after_rst_pt_ready", 32'(pt_ready), 32'd1);
        compare_model("reset_mid");

        // normal operation resumes after the abandoned point
        drv_busy = 2;
        offer(12'hC0F, 12'hFEE, 3, 1'b1);
        pt_valid = 1'b0;
        wait_idle();
        compare_model("recover");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
